// File: rtl/axi_stream_interconnect_m2s_a3_pkg.sv
// axi_stream_intc_pkg
// Shared types and helpers for the NUM-to-1 packet-atomic AXI-stream mux.
//   intc_state_e : arbiter FSM states (IDLE arbitrates, LOCK forwards one packet)
//   MODE_ROBIN   : rotating priority starting after the last grant
//   MODE_FIXED   : lowest requesting index wins
//   rr_pick      : first set request bit at or above ptr, wrapping at num
package axi_stream_intc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } intc_state_e;

  localparam string MODE_ROBIN = "ROBIN";
  localparam string MODE_FIXED = "FIXED";

  // Widest supported channel count; rr_pick works on a request vector of this width.
  localparam int MAX_NUM = 32;

  // Wraps by comparing against num rather than relying on 2^N overflow,
  // so indexes at or above num can never be returned.
  // A ptr of zero turns this into a plain lowest-index search.
  function automatic logic [4:0] rr_pick(input logic [MAX_NUM-1:0] req,
                                         input logic [4:0]         ptr,
                                         input int                 num);
    logic [4:0] pick;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_NUM; k++) begin
      idx = int'(ptr) + k;
      if (idx >= num) idx = idx - num;
      if ((k < num) && !found && req[idx[4:0]]) begin
        pick  = idx[4:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axi_stream_inf.sv
// axi_stream_inf
// Plain AXI-stream bundle used for both the upstream sources and the merged output.
//   axis_tdata  DSIZE  payload
//   axis_tkeep  KSIZE  byte qualifiers
//   axis_tuser  1      sideband flag
//   axis_tlast  1      end of packet
//   axis_tvalid 1      beat present
//   axis_tready 1      beat taken
interface axi_stream_inf #(
  parameter int DSIZE = 8,
  parameter int KSIZE = 1
);
  logic [DSIZE-1:0] axis_tdata;
  logic [KSIZE-1:0] axis_tkeep;
  logic             axis_tuser;
  logic             axis_tlast;
  logic             axis_tvalid;
  logic             axis_tready;

  modport master (
    output axis_tdata, axis_tkeep, axis_tuser, axis_tlast, axis_tvalid,
    input  axis_tready
  );

  modport slaver (
    input  axis_tdata, axis_tkeep, axis_tuser, axis_tlast, axis_tvalid,
    output axis_tready
  );
endinterface

// File: rtl/axi_stream_interconnect_m2s_a3_skid.sv
// axis_skid_buffer_2e
// Two-entry valid/ready register slice. The output register plus one skid
// register let the upstream side see a registered ready while still moving
// one word per clock when the sink keeps out_ready high.
//   aclk, aresetn        clock, async active-low reset
//   in_data/valid/ready  upstream side; in_ready is low only when both entries hold data
//   out_data/valid/ready downstream side; out_data is held while out_valid & !out_ready
module axis_skid_buffer_2e #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] skid_data;
  logic         skid_valid;
  logic         push;
  logic         pop;

  // The skid entry only fills while the output entry is stalled, so a valid
  // skid entry means the buffer is full. in_ready comes straight off that flop.
  assign in_ready = ~skid_valid;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      // No push is possible while full; drain the skid word into the output.
      if (pop) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (push) begin
      if (!out_valid || pop) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_stream_interconnect_m2s_a3.sv
// axi_stream_interconnect_m2s_a3
// NUM-to-1 AXI-stream mux with packet-atomic arbitration. A granted source
// owns the output until its tlast beat is taken. The merged stream leaves
// through a registered 2-entry skid buffer and carries the source index.
//   aclk, aresetn  clock, async active-low reset
//   ch_en          per-channel enable, only looked at while arbitrating
//   s00[NUM]       upstream sources
//   m00            merged output stream
//   m00_sid        source index of the beat on m00, qualified by m00.axis_tvalid
//   busy           high while a packet is locked to a source
module axi_stream_interconnect_m2s_a3
  import axi_stream_intc_pkg::*;
#(
  parameter int    NUM   = 8,
  parameter int    DSIZE = 8,
  parameter int    KSIZE = ((DSIZE / 8) > 1) ? (DSIZE / 8) : 1,
  parameter int    NSIZE = (NUM > 1) ? $clog2(NUM) : 1,
  parameter string MODE  = "ROBIN"
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [NUM-1:0]   ch_en,
  axi_stream_inf.slaver    s00 [NUM],
  axi_stream_inf.master    m00,
  output logic [NSIZE-1:0] m00_sid,
  output logic             busy
);

  localparam int W = NSIZE + KSIZE + 2 + DSIZE;
  localparam bit FIXED_MODE = (MODE == MODE_FIXED);
  localparam logic [NSIZE-1:0] LAST_IDX = NSIZE'(NUM - 1);

  logic [NUM-1:0]   ch_valid;
  logic [NUM-1:0]   ch_last;
  logic [NUM-1:0]   ch_user;
  logic [NUM-1:0]   ch_ready;
  logic [DSIZE-1:0] ch_data [NUM];
  logic [KSIZE-1:0] ch_keep [NUM];

  // Interface arrays cannot be indexed by a run-time grant, so each channel
  // is copied into plain arrays that the grant mux can select from.
  for (genvar i = 0; i < NUM; i++) begin : g_flat
    assign ch_valid[i]        = s00[i].axis_tvalid;
    assign ch_last[i]         = s00[i].axis_tlast;
    assign ch_user[i]         = s00[i].axis_tuser;
    assign ch_data[i]         = s00[i].axis_tdata;
    assign ch_keep[i]         = s00[i].axis_tkeep;
    assign s00[i].axis_tready = ch_ready[i];
  end

  intc_state_e      state;
  intc_state_e      state_next;
  logic [NSIZE-1:0] grant;
  logic [NSIZE-1:0] rr_ptr;
  logic [NSIZE-1:0] pick;
  logic [NUM-1:0]   req;
  logic             sel_valid;
  logic             sel_last;
  logic             skid_in_valid;
  logic             skid_in_ready;
  logic             accept;
  logic             pkt_done;
  logic [W-1:0]     in_payload;
  logic [W-1:0]     out_payload;

  assign req = ch_valid & ch_en;

  // FIXED mode is the rotating search with the start point pinned at zero.
  assign pick = NSIZE'(rr_pick(32'(req), FIXED_MODE ? 5'd0 : 5'(rr_ptr), NUM));

  assign sel_valid     = ch_valid[grant];
  assign sel_last      = ch_last[grant];
  assign skid_in_valid = (state == LOCK) & sel_valid;
  assign accept        = skid_in_valid & skid_in_ready;
  assign pkt_done      = accept & sel_last;
  assign in_payload    = {grant, ch_keep[grant], ch_user[grant], ch_last[grant], ch_data[grant]};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_next;
  end

  // Arbitration takes its own IDLE cycle; the lock releases only on the tlast beat.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (|req)    state_next = LOCK;
      LOCK: if (pkt_done) state_next = IDLE;
      default:           state_next = IDLE;
    endcase
  end

  // Only the granted source sees ready, and only while locked.
  always_comb begin
    busy     = (state == LOCK);
    ch_ready = '0;
    if (state == LOCK) ch_ready[grant] = skid_in_ready;
  end

  // Grant is captured when leaving IDLE; the rotation point moves past the
  // source that just finished, wrapping at NUM.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      if ((state == IDLE) && (|req)) grant <= pick;
      if (pkt_done) rr_ptr <= (grant == LAST_IDX) ? '0 : grant + NSIZE'(1);
    end
  end

  axis_skid_buffer_2e #(.W(W)) u_skid (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_data   (in_payload),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_in_ready),
    .out_data  (out_payload),
    .out_valid (m00.axis_tvalid),
    .out_ready (m00.axis_tready)
  );

  assign m00.axis_tdata = out_payload[DSIZE-1:0];
  assign m00.axis_tlast = out_payload[DSIZE];
  assign m00.axis_tuser = out_payload[DSIZE+1];
  assign m00.axis_tkeep = out_payload[DSIZE+2 +: KSIZE];
  assign m00_sid        = out_payload[DSIZE+2+KSIZE +: NSIZE];

endmodule

// File: tb/tb_axi_stream_interconnect_m2s_a3.sv
// tb_axi_stream_interconnect_m2s_a3
// Drives a ROBIN and a FIXED instance (NUM=4, DSIZE=8) with identical packet
// traffic. Expected output order is built at packet level from the
// arbitration rules; every m00 beat is compared field by field.
module tb_axi_stream_interconnect_m2s_a3;

  localparam int NUM = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       keep;
    logic       user;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [1:0] sid;
    logic       last;
    logic       user;
    logic       keep;
    logic [7:0] data;
  } obs_t;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [3:0] ch_en;

  always #5 aclk = ~aclk;

  axi_stream_inf #(.DSIZE(8), .KSIZE(1)) s_rr [NUM] ();
  axi_stream_inf #(.DSIZE(8), .KSIZE(1)) s_fx [NUM] ();
  axi_stream_inf #(.DSIZE(8), .KSIZE(1)) m_rr ();
  axi_stream_inf #(.DSIZE(8), .KSIZE(1)) m_fx ();

  logic [1:0] sid_obs  [2];
  logic       busy_obs [2];

  axi_stream_interconnect_m2s_a3 #(
    .NUM(4), .DSIZE(8), .KSIZE(1), .NSIZE(2), .MODE("ROBIN")
  ) dut_rr (
    .aclk(aclk), .aresetn(aresetn), .ch_en(ch_en),
    .s00(s_rr), .m00(m_rr), .m00_sid(sid_obs[0]), .busy(busy_obs[0])
  );

  axi_stream_interconnect_m2s_a3 #(
    .NUM(4), .DSIZE(8), .KSIZE(1), .NSIZE(2), .MODE("FIXED")
  ) dut_fx (
    .aclk(aclk), .aresetn(aresetn), .ch_en(ch_en),
    .s00(s_fx), .m00(m_fx), .m00_sid(sid_obs[1]), .busy(busy_obs[1])
  );

  logic       tv   [2][NUM];
  logic [7:0] td   [2][NUM];
  logic       tk   [2][NUM];
  logic       tu   [2][NUM];
  logic       tl   [2][NUM];
  logic       rdy  [2][NUM];
  logic       mrdy [2];
  logic       mv   [2];
  obs_t       mdat [2];

  for (genvar c = 0; c < NUM; c++) begin : g_src
    assign s_rr[c].axis_tvalid = tv[0][c];
    assign s_rr[c].axis_tdata  = td[0][c];
    assign s_rr[c].axis_tkeep  = tk[0][c];
    assign s_rr[c].axis_tuser  = tu[0][c];
    assign s_rr[c].axis_tlast  = tl[0][c];
    assign rdy[0][c]           = s_rr[c].axis_tready;
    assign s_fx[c].axis_tvalid = tv[1][c];
    assign s_fx[c].axis_tdata  = td[1][c];
    assign s_fx[c].axis_tkeep  = tk[1][c];
    assign s_fx[c].axis_tuser  = tu[1][c];
    assign s_fx[c].axis_tlast  = tl[1][c];
    assign rdy[1][c]           = s_fx[c].axis_tready;
  end

  assign m_rr.axis_tready = mrdy[0];
  assign m_fx.axis_tready = mrdy[1];
  assign mv[0]   = m_rr.axis_tvalid;
  assign mv[1]   = m_fx.axis_tvalid;
  assign mdat[0] = {sid_obs[0], m_rr.axis_tlast, m_rr.axis_tuser, m_rr.axis_tkeep, m_rr.axis_tdata};
  assign mdat[1] = {sid_obs[1], m_fx.axis_tlast, m_fx.axis_tuser, m_fx.axis_tkeep, m_fx.axis_tdata};

  // Source beats still to present, unplanned packets, expected output stream.
  beat_t       srcq [2][NUM][$];
  beat_t       mq   [2][NUM][$];
  obs_t        expq [2][$];
  int          model_ptr [2];
  logic        sacc [2][NUM];
  int          sent [2][NUM];
  logic        prev_stall [2];
  obs_t        prev_dat [2];
  int          prev_cyc [2];
  logic        prev_last [2];
  bit          first_beat [2];
  int          cyc;
  int unsigned ready_pct;
  bit          strict_timing;
  int          checks;
  int          failures;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // Queues one packet of random beats on channel c of both instances.
  task automatic loadPacket(input int c, input int len);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.data = 8'($urandom);
      bt.keep = 1'($urandom);
      bt.user = 1'($urandom);
      bt.last = (b == len - 1);
      for (int d = 0; d < 2; d++) begin
        srcq[d][c].push_back(bt);
        mq[d][c].push_back(bt);
      end
    end
  endtask

  // Packet-level arbitration: every loaded channel is requesting, so ROBIN
  // serves them in rotation from the pointer and FIXED always takes the lowest.
  task automatic planOrder();
    int   win;
    beat_t bt;
    obs_t  o;
    for (int d = 0; d < 2; d++) begin
      win = 0;
      while (win >= 0) begin
        win = -1;
        for (int k = 0; k < NUM; k++) begin
          int c;
          c = (d == 0) ? (model_ptr[d] + k) % NUM : k;
          if (win < 0 && mq[d][c].size() != 0) win = c;
        end
        if (win >= 0) begin
          do begin
            bt = mq[d][win].pop_front();
            o  = {2'(win), bt.last, bt.user, bt.keep, bt.data};
            expq[d].push_back(o);
          end while (!bt.last);
          model_ptr[d] = (win + 1) % NUM;
        end
      end
    end
  endtask

  task automatic consumeBeat(input int d);
    obs_t e;
    if (expq[d].size() == 0) begin
      checkOutput("extra_beat", 32'(expq[d].size()), 32'd1);
    end else begin
      e = expq[d].pop_front();
      checkOutput(d == 0 ? "beat_rr" : "beat_fx", 32'(mdat[d]), 32'(e));
    end
    if (strict_timing && !first_beat[d])
      checkOutput("gap", 32'(cyc), 32'(prev_last[d] ? prev_cyc[d] + 2 : prev_cyc[d] + 1));
    prev_cyc[d]   = cyc;
    prev_last[d]  = mdat[d].last;
    first_beat[d] = 1'b0;
  endtask

  // One clock: sink checks and ready, then sources advance on the last handshake.
  task automatic applyStimulus();
    beat_t bt;
    @(negedge aclk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (prev_stall[d])
        checkOutput("hold", 32'({mv[d], mdat[d]}), 32'({1'b1, prev_dat[d]}));
      mrdy[d] = ($urandom_range(99) < ready_pct);
      if (mv[d] && mrdy[d]) consumeBeat(d);
      prev_stall[d] = mv[d] && !mrdy[d];
      prev_dat[d]   = mdat[d];
      for (int c = 0; c < NUM; c++) begin
        if (sacc[d][c]) begin
          void'(srcq[d][c].pop_front());
          sent[d][c]++;
        end
        if (srcq[d][c].size() != 0) begin
          bt = srcq[d][c][0];
          tv[d][c] = 1'b1;
          td[d][c] = bt.data;
          tk[d][c] = bt.keep;
          tu[d][c] = bt.user;
          tl[d][c] = bt.last;
        end else begin
          tv[d][c] = 1'b0;
        end
        sacc[d][c] = tv[d][c] && rdy[d][c];
      end
    end
  endtask

  function automatic bit pending();
    bit p;
    p = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (expq[d].size() != 0 || mv[d]) p = 1'b1;
      for (int c = 0; c < NUM; c++) if (srcq[d][c].size() != 0) p = 1'b1;
    end
    return p;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain_left", 32'(pending()), 32'd0);
  endtask

  task automatic startScenario(input int unsigned pct, input bit strict);
    ready_pct     = pct;
    strict_timing = strict;
    for (int d = 0; d < 2; d++) first_beat[d] = 1'b1;
  endtask

  initial begin
    int n;
    int nload;
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    ready_pct = 100;
    aresetn   = 1'b0;
    ch_en     = 4'hF;
    for (int d = 0; d < 2; d++) begin
      mrdy[d]       = 1'b0;
      prev_stall[d] = 1'b0;
      model_ptr[d]  = 0;
      for (int c = 0; c < NUM; c++) begin
        tv[d][c] = 1'b0; td[d][c] = '0; tk[d][c] = 1'b0; tu[d][c] = 1'b0; tl[d][c] = 1'b0;
        sacc[d][c] = 1'b0;
        sent[d][c] = 0;
      end
    end
    repeat (3) applyStimulus();
    for (int d = 0; d < 2; d++) begin
      checkOutput("rst_valid", 32'(mv[d]), 32'd0);
      checkOutput("rst_busy", 32'(busy_obs[d]), 32'd0);
      checkOutput("rst_sid", 32'(mdat[d].sid), 32'd0);
      checkOutput("rst_tready", 32'({rdy[d][3], rdy[d][2], rdy[d][1], rdy[d][0]}), 32'd0);
    end
    aresetn = 1'b1;

    // Two simultaneous 3-beat packets: no interleaving, one idle cycle between.
    startScenario(100, 1'b1);
    loadPacket(0, 3);
    loadPacket(2, 3);
    planOrder();
    drain(200);

    // Every channel streaming single-beat packets.
    startScenario(100, 1'b1);
    for (int r = 0; r < 2; r++) for (int c = 0; c < NUM; c++) loadPacket(c, 1);
    planOrder();
    drain(200);

    // New requests arriving while ch3 is mid-packet wait for its tlast.
    startScenario(100, 1'b1);
    for (int d = 0; d < 2; d++) sent[d][3] = 0;
    loadPacket(3, 5);
    planOrder();
    n = 0;
    while (sent[0][3] < 2 && n < 50) begin
      applyStimulus();
      n++;
    end
    checkOutput("ch3_mid", 32'(sent[0][3] >= 2), 32'd1);
    loadPacket(1, 2);
    loadPacket(0, 2);
    planOrder();
    drain(200);

    // Disabled channel is never granted; enabling it starts the packet.
    startScenario(100, 1'b1);
    ch_en = 4'b1011;
    loadPacket(2, 1);
    planOrder();
    repeat (4) applyStimulus();
    for (int d = 0; d < 2; d++) begin
      checkOutput("dis_busy", 32'(busy_obs[d]), 32'd0);
      checkOutput("dis_tready", 32'(rdy[d][2]), 32'd0);
      checkOutput("dis_valid", 32'(mv[d]), 32'd0);
    end
    ch_en = 4'b1111;
    applyStimulus();
    for (int d = 0; d < 2; d++) begin
      checkOutput("en_busy", 32'(busy_obs[d]), 32'd1);
      checkOutput("en_tready", 32'(rdy[d][2]), 32'd1);
    end
    applyStimulus();
    for (int d = 0; d < 2; d++) begin
      checkOutput("en_valid", 32'(mv[d]), 32'd1);
      checkOutput("en_sid", 32'(mdat[d].sid), 32'd2);
    end
    drain(100);

    // Reset in the middle of a 6-beat packet.
    startScenario(100, 1'b1);
    for (int d = 0; d < 2; d++) sent[d][1] = 0;
    loadPacket(1, 6);
    planOrder();
    n = 0;
    while (sent[0][1] < 3 && n < 50) begin
      applyStimulus();
      n++;
    end
    checkOutput("rst_mid_reach", 32'(sent[0][1] >= 3), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("arst_valid", 32'(mv[d]), 32'd0);
      checkOutput("arst_busy", 32'(busy_obs[d]), 32'd0);
      checkOutput("arst_tready", 32'({rdy[d][3], rdy[d][2], rdy[d][1], rdy[d][0]}), 32'd0);
      expq[d].delete();
      model_ptr[d]  = 0;
      prev_stall[d] = 1'b0;
      for (int c = 0; c < NUM; c++) begin
        srcq[d][c].delete();
        mq[d][c].delete();
        sacc[d][c] = 1'b0;
      end
    end
    repeat (2) applyStimulus();
    aresetn = 1'b1;
    startScenario(100, 1'b1);
    for (int c = 0; c < NUM; c++) loadPacket(c, 1);
    planOrder();
    drain(200);

    // Long packet under random output backpressure.
    startScenario(70, 1'b0);
    loadPacket(1, 8);
    planOrder();
    drain(400);

    // Random packet mixes under backpressure.
    for (int r = 0; r < 6; r++) begin
      startScenario(70, 1'b0);
      nload = 0;
      for (int c = 0; c < NUM; c++) begin
        if ($urandom_range(1) == 1) begin
          for (int p = 0; p < int'($urandom_range(2, 1)); p++) begin
            loadPacket(c, int'($urandom_range(6, 1)));
            nload++;
          end
        end
      end
      if (nload == 0) loadPacket(r % NUM, 3);
      planOrder();
      drain(2000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
